// File: rtl/mdma_splitter_pkg.sv
// Shared definitions for the MDMA splitter: FSM states, chunk status codes
// and the helper that sizes the chunk-offset field from MAX_CHUNK.
package mdma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // Smallest n with 2**n >= max_chunk; exact for the power-of-two chunk sizes used here.
  function automatic int unsigned chunk_log2(input int unsigned max_chunk);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < max_chunk) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mdma_splitter_if.sv
// Request, completion, DMA-command and DMA-report channels of the splitter.
// slave is the splitter's view, master is the view of the surrounding system.
interface mdma_splitter_if #(
  parameter int SRC_ADDRESS_BITS = 31,
  parameter int DST_ADDRESS_BITS = 31,
  parameter int LENGTH_BITS      = 16,
  parameter int REQ_LENGTH_BITS  = 24
);
  logic [SRC_ADDRESS_BITS-1:0] req_src_addr;
  logic [DST_ADDRESS_BITS-1:0] req_dst_addr;
  logic [REQ_LENGTH_BITS-1:0]  req_bytes;
  logic                        req_valid;
  logic                        req_ready;

  logic [REQ_LENGTH_BITS-1:0]  done_bytes;
  logic [1:0]                  done_status;
  logic                        done_valid;
  logic                        done_ready;

  logic [SRC_ADDRESS_BITS-1:0] dma_cmd_src_addr;
  logic [DST_ADDRESS_BITS-1:0] dma_cmd_dst_addr;
  logic [LENGTH_BITS-1:0]      dma_cmd_bytes;
  logic                        dma_cmd_valid;
  logic                        dma_cmd_ready;

  logic [LENGTH_BITS-1:0]      dma_rpt_bytes;
  logic [1:0]                  dma_rpt_status;
  logic                        dma_rpt_valid;
  logic                        dma_rpt_ready;

  modport slave (
    input  req_src_addr, req_dst_addr, req_bytes, req_valid, done_ready,
           dma_cmd_ready, dma_rpt_bytes, dma_rpt_status, dma_rpt_valid,
    output req_ready, done_bytes, done_status, done_valid,
           dma_cmd_src_addr, dma_cmd_dst_addr, dma_cmd_bytes, dma_cmd_valid,
           dma_rpt_ready
  );

  modport master (
    output req_src_addr, req_dst_addr, req_bytes, req_valid, done_ready,
           dma_cmd_ready, dma_rpt_bytes, dma_rpt_status, dma_rpt_valid,
    input  req_ready, done_bytes, done_status, done_valid,
           dma_cmd_src_addr, dma_cmd_dst_addr, dma_cmd_bytes, dma_cmd_valid,
           dma_rpt_ready
  );
endinterface

// File: rtl/mdma_splitter_chunk_calc.sv
// Combinational chunk sizer: the largest piece of the remaining transfer that
// crosses no MAX_CHUNK boundary at either the source or the destination.
module mdma_chunk_calc #(
  parameter int LENGTH_BITS     = 16,
  parameter int REQ_LENGTH_BITS = 24,
  parameter int MAX_CHUNK       = 256,
  parameter int OFF_BITS        = 8
) (
  input  logic [OFF_BITS-1:0]        i_src_off,
  input  logic [OFF_BITS-1:0]        i_dst_off,
  input  logic [REQ_LENGTH_BITS-1:0] i_rem,
  output logic [LENGTH_BITS-1:0]     o_chunk
);
  localparam int W = (REQ_LENGTH_BITS > LENGTH_BITS) ? REQ_LENGTH_BITS : LENGTH_BITS;

  logic [LENGTH_BITS-1:0] w_src_room;
  logic [LENGTH_BITS-1:0] w_dst_room;
  logic [LENGTH_BITS-1:0] w_room;

  // Rooms are 1..MAX_CHUNK, which always fits LENGTH_BITS.
  always_comb begin
    w_src_room = LENGTH_BITS'(MAX_CHUNK) - LENGTH_BITS'(i_src_off);
    w_dst_room = LENGTH_BITS'(MAX_CHUNK) - LENGTH_BITS'(i_dst_off);
    w_room     = (w_dst_room < w_src_room) ? w_dst_room : w_src_room;
    o_chunk    = (W'(i_rem) < W'(w_room)) ? LENGTH_BITS'(i_rem) : w_room;
  end

endmodule

// File: rtl/mdma_splitter.sv
// Splits a copy request into MAX_CHUNK-aligned DMA commands, keeps at most
// MAX_OUTSTANDING unreported, and returns one completion. Option: MDMA_SPLITTER_ERR_ABORT_EN.
module mdma_splitter
  import mdma_pkg::*;
#(
  parameter int SRC_ADDRESS_BITS = 31,
  parameter int DST_ADDRESS_BITS = 31,
  parameter int LENGTH_BITS      = 16,
  parameter int REQ_LENGTH_BITS  = 24,
  parameter int MAX_CHUNK        = 256,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  mdma_splitter_if.slave  bus
);
  localparam int         OFF_BITS = chunk_log2(MAX_CHUNK);
  localparam logic [2:0] MAX_OUT  = 3'(MAX_OUTSTANDING);

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic                        r_live;
  logic [SRC_ADDRESS_BITS-1:0] r_src;
  logic [DST_ADDRESS_BITS-1:0] r_dst;
  logic [REQ_LENGTH_BITS-1:0]  r_rem;
  logic [LENGTH_BITS-1:0]      r_chunk;
  logic [LENGTH_BITS-1:0]      w_chunk;
  logic [2:0]                  r_outstanding;
  logic [REQ_LENGTH_BITS-1:0]  r_done_bytes;
  logic [1:0]                  r_done_status;

  logic w_req_ready, w_cmd_valid, w_rpt_ready, w_done_valid;
  logic w_req_fire, w_cmd_fire, w_rpt_fire, w_last, w_stop;

  mdma_chunk_calc #(
    .LENGTH_BITS     (LENGTH_BITS),
    .REQ_LENGTH_BITS (REQ_LENGTH_BITS),
    .MAX_CHUNK       (MAX_CHUNK),
    .OFF_BITS        (OFF_BITS)
  ) u_chunk_calc (
    .i_src_off (r_src[OFF_BITS-1:0]),
    .i_dst_off (r_dst[OFF_BITS-1:0]),
    .i_rem     (r_rem),
    .o_chunk   (w_chunk)
  );

  // r_live holds req_ready low until the first clock edge after reset release.
  assign w_req_ready  = (r_state == S_IDLE) && r_live;
  assign w_cmd_valid  = (r_state == S_ISSUE) && (r_outstanding < MAX_OUT);
  assign w_rpt_ready  = (r_state == S_CALC) || (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_done_valid = (r_state == S_DONE);

  assign w_req_fire = w_req_ready && bus.req_valid;
  assign w_cmd_fire = w_cmd_valid && bus.dma_cmd_ready;
  assign w_rpt_fire = w_rpt_ready && bus.dma_rpt_valid;
  assign w_last     = (r_rem == REQ_LENGTH_BITS'(r_chunk));

`ifdef MDMA_SPLITTER_ERR_ABORT_EN
  assign w_stop = w_rpt_fire && (bus.dma_rpt_status != OKAY);
`else
  assign w_stop = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  // A zero-length request passes through S_CALC so its completion lands two cycles after acceptance.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req_fire) w_state_nxt = S_CALC;
      S_CALC: begin
        if (r_rem == '0)  w_state_nxt = S_DONE;
        else if (w_stop)  w_state_nxt = S_DRAIN;
        else              w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_cmd_fire)   w_state_nxt = (w_last || w_stop) ? S_DRAIN : S_CALC;
        else if (w_stop)  w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (r_outstanding == '0) w_state_nxt = S_DONE;
      S_DONE:  if (bus.done_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_live        <= 1'b0;
      r_src         <= '0;
      r_dst         <= '0;
      r_rem         <= '0;
      r_chunk       <= '0;
      r_outstanding <= '0;
      r_done_bytes  <= '0;
      r_done_status <= OKAY;
    end else begin
      r_live <= 1'b1;
      if (w_req_fire) begin
        r_src         <= bus.req_src_addr;
        r_dst         <= bus.req_dst_addr;
        r_rem         <= bus.req_bytes;
        r_done_bytes  <= '0;
        r_done_status <= OKAY;
      end
      if (r_state == S_CALC) r_chunk <= w_chunk;
      // Addresses wrap naturally at their width; rem never underflows since chunk <= rem.
      if (w_cmd_fire) begin
        r_src <= r_src + SRC_ADDRESS_BITS'(r_chunk);
        r_dst <= r_dst + DST_ADDRESS_BITS'(r_chunk);
        r_rem <= r_rem - REQ_LENGTH_BITS'(r_chunk);
      end
      if (w_rpt_fire) begin
        r_done_bytes  <= r_done_bytes + REQ_LENGTH_BITS'(bus.dma_rpt_bytes);
        r_done_status <= r_done_status | bus.dma_rpt_status;
      end
      unique case ({w_cmd_fire, w_rpt_fire})
        2'b10:   r_outstanding <= r_outstanding + 3'd1;
        2'b01:   r_outstanding <= r_outstanding - 3'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign bus.req_ready        = w_req_ready;
  assign bus.dma_cmd_valid    = w_cmd_valid;
  assign bus.dma_rpt_ready    = w_rpt_ready;
  assign bus.done_valid       = w_done_valid;
  assign bus.dma_cmd_src_addr = r_src;
  assign bus.dma_cmd_dst_addr = r_dst;
  assign bus.dma_cmd_bytes    = r_chunk;
  assign bus.done_bytes       = r_done_bytes;
  assign bus.done_status      = r_done_status;

endmodule

// File: tb/tb_mdma_splitter.sv
// Self-checking bench for mdma_splitter: directed cases plus randomized requests
// against a chunk-list model with a randomly stalling, randomly reporting DMA.
module tb_mdma_splitter;
  localparam int SA = 31;
  localparam int DA = 31;
  localparam int LB = 16;
  localparam int RL = 24;
  localparam int MC = 256;
  localparam int MO = 4;

`ifdef MDMA_SPLITTER_ERR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef struct {
    logic [SA-1:0] src;
    logic [DA-1:0] dst;
    int            bytes;
  } chunk_t;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  mdma_splitter_if #(.SRC_ADDRESS_BITS(SA), .DST_ADDRESS_BITS(DA),
                     .LENGTH_BITS(LB), .REQ_LENGTH_BITS(RL)) bus ();

  mdma_splitter #(
    .SRC_ADDRESS_BITS (SA), .DST_ADDRESS_BITS (DA), .LENGTH_BITS (LB),
    .REQ_LENGTH_BITS  (RL), .MAX_CHUNK (MC), .MAX_OUTSTANDING (MO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  chunk_t exp_q[$];
  int     pend_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: greedy split so no chunk crosses a MAX_CHUNK boundary at either end.
  task automatic plan(input logic [SA-1:0] src, input logic [DA-1:0] dst, input int bytes);
    logic [SA-1:0] s;
    logic [DA-1:0] d;
    int left, c, rs, rd;
    chunk_t e;
    s = src; d = dst; left = bytes;
    exp_q.delete();
    while (left > 0) begin
      rs = MC - int'(longint'(s) % MC);
      rd = MC - int'(longint'(d) % MC);
      c  = left;
      if (rs < c) c = rs;
      if (rd < c) c = rd;
      e.src = s; e.dst = d; e.bytes = c;
      exp_q.push_back(e);
      s = s + SA'(c);
      d = d + DA'(c);
      left -= c;
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.done_ready    = 1'b0;
    bus.dma_cmd_ready = 1'b0;
    bus.dma_rpt_valid = 1'b0;
    bus.dma_rpt_bytes = '0;
    bus.dma_rpt_status = 2'd0;
  endtask

  task automatic send_req(input logic [SA-1:0] src, input logic [DA-1:0] dst, input int bytes);
    int w;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(posedge aclk); #1; w++;
    end
    check("req_ready_wait", bus.req_ready, 1);
    bus.req_src_addr = src;
    bus.req_dst_addr = dst;
    bus.req_bytes    = RL'(bytes);
    bus.req_valid    = 1'b1;
    @(posedge aclk); #1;
    bus.req_valid    = 1'b0;
  endtask

  // One full transfer; reports are withheld for the first `hold` cycles and
  // the report with index err_idx carries SLVERR.
  task automatic run_xfer(input logic [SA-1:0] src, input logic [DA-1:0] dst, input int bytes,
                          input int rdy_pct, input int rpt_pct, input int hold, input int err_idx);
    int issued, reported, rpt_n;
    longint sum_rep;
    logic [1:0] st_or;
    bit aborted, abort_nxt, finished;
    chunk_t e;
    issued = 0; reported = 0; rpt_n = 0; sum_rep = 0; st_or = 2'd0;
    aborted = 0; abort_nxt = 0; finished = 0;
    plan(src, dst, bytes);
    pend_q.delete();
    send_req(src, dst, bytes);
    for (int c = 1; c <= 3000 && !finished; c++) begin
      idle_inputs();
      if (c == 1) check("lat_c1_cmd", bus.dma_cmd_valid, 0);
      if (c == 2) begin
        if (bytes > 0) check("lat_c2_cmd", bus.dma_cmd_valid, 1);
        else begin
          check("zero_done_valid", bus.done_valid, 1);
          check("zero_done_bytes", bus.done_bytes, 0);
        end
      end
      if (hold > 0 && c == hold) begin
        check("held_issued", issued, MO);
        check("held_no_cmd", bus.dma_cmd_valid, 0);
      end
      if (bus.done_valid) begin
        check("done_bytes", bus.done_bytes, sum_rep);
        check("done_status", bus.done_status, st_or);
        check("done_outstanding", issued - reported, 0);
        if (!(ABORT_EN && aborted)) check("done_all_issued", exp_q.size(), 0);
        bus.done_ready = 1'b1;
        @(posedge aclk); #1;
        bus.done_ready = 1'b0;
        check("idle_after_done", bus.req_ready, 1);
        finished = 1;
      end else begin
        if (aborted) check("abort_no_cmd", bus.dma_cmd_valid, 0);
        if (pend_q.size() > 0) check("rpt_ready", bus.dma_rpt_ready, 1);
        if (c > hold && pend_q.size() > 0 && $urandom_range(99) < rpt_pct) begin
          bus.dma_rpt_valid  = 1'b1;
          bus.dma_rpt_bytes  = LB'(pend_q[0]);
          bus.dma_rpt_status = (rpt_n == err_idx) ? 2'd2 : 2'd0;
          if (bus.dma_rpt_ready) begin
            sum_rep += pend_q.pop_front();
            st_or    = st_or | bus.dma_rpt_status;
            if (ABORT_EN && bus.dma_rpt_status != 2'd0) abort_nxt = 1;
            reported++;
            rpt_n++;
          end
        end
        if (bus.dma_cmd_valid) begin
          check("out_limit", (issued - reported + int'(bus.dma_rpt_valid && bus.dma_rpt_ready)) < MO, 1);
          check("cmd_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0 && $urandom_range(99) < rdy_pct) begin
            e = exp_q.pop_front();
            bus.dma_cmd_ready = 1'b1;
            check("cmd_src", bus.dma_cmd_src_addr, e.src);
            check("cmd_dst", bus.dma_cmd_dst_addr, e.dst);
            check("cmd_bytes", bus.dma_cmd_bytes, e.bytes);
            check("no_cross", (longint'(bus.dma_cmd_src_addr) % MC) + bus.dma_cmd_bytes <= MC, 1);
            issued++;
            pend_q.push_back(e.bytes);
          end
        end
        @(posedge aclk); #1;
        aborted = abort_nxt;
      end
    end
    idle_inputs();
    if (!finished) check("done_timeout", 0, 1);
  endtask

  // Reset pulse after the second of eight commands: everything must clear and stay quiet.
  task automatic reset_midway();
    int issued, w;
    issued = 0; w = 0;
    send_req(31'h0, 31'h4000, 2048);
    while (issued < 2 && w < 50) begin
      bus.dma_cmd_ready = bus.dma_cmd_valid;
      if (bus.dma_cmd_valid) issued++;
      @(posedge aclk); #1; w++;
    end
    bus.dma_cmd_ready = 1'b0;
    check("rst_two_cmds", issued, 2);
    aresetn = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_cmd_valid", bus.dma_cmd_valid, 0);
    check("rst_rpt_ready", bus.dma_rpt_ready, 0);
    check("rst_done_valid", bus.done_valid, 0);
    check("rst_done_bytes", bus.done_bytes, 0);
    check("rst_done_status", bus.done_status, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("rst_req_ready_after", bus.req_ready, 1);
    for (int i = 0; i < 10; i++) begin
      check("rst_quiet_done", bus.done_valid, 0);
      check("rst_quiet_cmd", bus.dma_cmd_valid, 0);
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    logic [SA-1:0] rs;
    logic [DA-1:0] rd;
    int rb, err;
    idle_inputs();
    bus.req_src_addr = '0;
    bus.req_dst_addr = '0;
    bus.req_bytes    = '0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("por_req_ready", bus.req_ready, 0);
    check("por_cmd_valid", bus.dma_cmd_valid, 0);
    check("por_done_valid", bus.done_valid, 0);
    check("por_rpt_ready", bus.dma_rpt_ready, 0);
    check("por_done_bytes", bus.done_bytes, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("por_req_ready_after", bus.req_ready, 1);

    run_xfer(31'h100, 31'h2000, 1024, 100, 100, 0, -1);
    run_xfer(31'hF0, 31'h1008, 300, 100, 100, 0, -1);
    run_xfer(31'h40, 31'h80, 0, 100, 100, 0, -1);
    run_xfer(31'h0, 31'h0, 2048, 100, 100, 40, -1);
    run_xfer(31'h0, 31'h8000, 2048, 100, 100, 0, 1);
    run_xfer(31'h7FFF_FF80, 31'h7FFF_FFF0, 400, 70, 60, 0, -1);
    reset_midway();
    run_xfer(31'h123, 31'h456, 700, 80, 80, 0, -1);

    for (int t = 0; t < 14; t++) begin
      rs  = SA'($urandom);
      rd  = DA'($urandom);
      rb  = (t % 5 == 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 1400));
      err = ($urandom_range(3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_xfer(rs, rd, rb, int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 0, err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
